uart_rx_deframer: RTL
=====================

// Module: uart_rx_deframer
// PURPOSE
//  - Receive side of the UART: recovers 8N1-style frames from the serial line driven by the
//    transmit FSM/shift path, checks framing and presents each byte with a valid/ready handshake.
//  - Sits between the pad (rx_serial) and the byte consumer; shares the baud count with the TX.
// PARAMETERS
//  CLKS_PER_BIT  5208  clk cycles per serial bit (50 MHz / 9600); legal >= 4
//  DATA_BITS     8     data bits per frame, LSB first; legal 5..8
// PORTS
//  clk          in   1          clock
//  rst          in   1          reset, synchronous, active-high
//  rx_serial    in   1          asynchronous serial input, idle high
//  rx_ready     in   1          consumer accepts rx_data when rx_valid & rx_ready
//  rx_data      out  DATA_BITS  received byte, stable while rx_valid
//  rx_valid     out  1          byte available; held until accepted
//  framing_err  out  1          1-cycle pulse: stop bit sampled low
//  overrun      out  1          1-cycle pulse: new byte completed while previous byte not accepted
//  busy         out  1          high in every state except IDLE
// BEHAVIOUR
//  - Input sync: 2-FF synchronizer (reset value 1) gives rx_s; the FSM sees only rx_s.
//  - Reset: state=IDLE, baud counter=0, bit index=0, shift reg=0; rx_data=0, rx_valid=0,
//    framing_err=0, overrun=0, busy=0. Reset mid-frame abandons the frame; no pulse.
//  - Baud counter: $clog2(CLKS_PER_BIT) bits; it is cleared on every state change and at each
//    sample point. H = CLKS_PER_BIT/2 (integer division).
//  - FSM states (uart_rx_state_t):
//    IDLE      : rx_s==0 -> START (counter cleared).
//    START     : at count H-1, re-sample rx_s: 0 -> DATA; 1 -> IDLE (glitch rejected, no pulse).
//    DATA      : at count CLKS_PER_BIT-1 (mid-bit), shift rx_s into MSB of shift reg (shift right).
//                The bit index advances; after bit DATA_BITS-1 -> STOP.
//    STOP      : at count CLKS_PER_BIT-1, sample rx_s:
//                1 -> load rx_data from shift reg, rx_valid<=1 next cycle, -> IDLE.
//                0 -> framing_err pulse, byte discarded, rx_data/rx_valid unchanged, -> WAIT_HIGH.
//    WAIT_HIGH : stay until rx_s==1 (break/line-low protection), then -> IDLE.
//  - Latency: rx_valid rises 1 cycle after the stop-bit sample. The stop-bit sample is
//    2 + H + (DATA_BITS+1)*CLKS_PER_BIT cycles (+/-1) after the rx_serial falling edge.
//  - Handshake: rx_valid & rx_ready in a cycle -> rx_valid falls the next cycle. The setting of a
//    new byte and acceptance in the same cycle: set wins (rx_valid stays 1, new data, no overrun).
//  - Overrun: new byte completes while rx_valid=1 and rx_ready=0. Result: overrun pulse, rx_data
//    is overwritten with the new byte, and rx_valid stays 1.
//  - framing_err and overrun are registered and are never high for more than 1 cycle per event.
//  - Back-to-back frames: the next start edge is accepted from the cycle after the return to IDLE.
//    The bit timing tolerates start edges 0.5 bit after the stop-bit sample point.
//  - busy is a combinational decode of the state (state != IDLE).
// STRUCTURE
//  - uart_pkg: typedef enum logic [2:0] uart_rx_state_t {IDLE,START,DATA,STOP,WAIT_HIGH};
//    constants START_BIT=1'b0, STOP_BIT=1'b1, IDLE_LEVEL=1'b1 (shared with the TX FSM).
//  - One sub-module: sync_2ff (parameter RESET_VAL=1) for rx_serial. Everything else is a
//    single always_ff (state, counter, index, shift reg, outputs) plus an always_comb next-state.
// TESTING  (CLKS_PER_BIT=16, DATA_BITS=8, rx_ready=1 unless stated)
//  1. Frame 0xA5 (start, bits 1,0,1,0,0,1,0,1, stop) -> rx_data=0xA5, rx_valid 1 cycle,
//     framing_err=0, busy drops after the stop sample.
//  2. rx_serial low for 4 clks then high -> no rx_valid, FSM back in IDLE, busy low within 10 clks.
//  3. Frame 0x3C with stop bit=0, line held low 40 clks -> framing_err single pulse, no rx_valid,
//     busy=1 until line high; then frame 0x55 -> rx_data=0x55.
//  4. rx_ready=0, frames 0x11 then 0x22 back-to-back -> overrun pulse once, rx_data=0x22, rx_valid
//     held; rx_ready=1 for one cycle -> rx_valid=0 next cycle.
//  5. rst asserted during data bit 3 of 0xF0 -> all outputs at reset values next cycle, no pulse;
//     the following frame 0x0F is received correctly.
//  6. Loopback from the TX block, 256 random bytes at the same CLKS_PER_BIT -> all received in
//     order, zero framing_err/overrun.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and line-level constants
// also used by the transmit FSM.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } uart_rx_state_t;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input. Both flops reset to
// RESET_VAL so the synchronized line comes out of reset at its idle level.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_deframer.sv
// UART receive deframer: mid-bit sampling of start/data/stop bits, framing
// check, and a valid/ready byte interface with overrun detection.
module uart_rx_deframer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 5208,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_serial,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 framing_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LAST_BIT = IW'(DATA_BITS - 1);

  uart_rx_state_t         state, state_next;
  logic [CW-1:0]          cnt;
  logic [IW-1:0]          bit_idx;
  logic [DATA_BITS-1:0]   shift_reg;
  logic                   rx_s;
  logic                   sample;

  sync_2ff #(.RESET_VAL(IDLE_LEVEL)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx_serial),
    .q   (rx_s)
  );

  // NOTE: defaults first so every path assigns every output and no latch is inferred.
  always_comb begin
    state_next = state;
    sample     = 1'b0;
    unique case (state)
      IDLE: begin
        if (rx_s == START_BIT) state_next = START;
      end
      START: begin
        if (cnt == HALF_M1) begin
          sample     = 1'b1;
          state_next = (rx_s == START_BIT) ? DATA : IDLE;
        end
      end
      DATA: begin
        if (cnt == FULL_M1) begin
          sample = 1'b1;
          if (bit_idx == LAST_BIT) state_next = STOP;
        end
      end
      STOP: begin
        if (cnt == FULL_M1) begin
          sample     = 1'b1;
          state_next = (rx_s == STOP_BIT) ? IDLE : WAIT_HIGH;
        end
      end
      WAIT_HIGH: begin
        if (rx_s == IDLE_LEVEL) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shift_reg   <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      framing_err <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      state       <= state_next;
      framing_err <= 1'b0;
      overrun     <= 1'b0;

      // Counter restarts on every state change and at every sample point.
      if (state_next != state || sample || state == IDLE) cnt <= '0;
      else                                                cnt <= cnt + CW'(1);

      if (state == DATA && sample) begin
        shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
        bit_idx   <= (bit_idx == LAST_BIT) ? '0 : bit_idx + IW'(1);
      end else if (state == IDLE) begin
        bit_idx <= '0;
      end

      if (rx_valid && rx_ready) rx_valid <= 1'b0;

      // A completing byte overrides a same-cycle acceptance.
      if (state == STOP && sample) begin
        if (rx_s == STOP_BIT) begin
          rx_data  <= shift_reg;
          rx_valid <= 1'b1;
          if (rx_valid && !rx_ready) overrun <= 1'b1;
        end else begin
          framing_err <= 1'b1;
        end
      end
    end
  end

  assign busy = (state != IDLE);

endmodule
